// File: rtl/spi_register_port.sv
// SPI mode-0 slave front end: oversamples ss_n/sclk/mosi on the system clock and
// decodes header/data frames into single-cycle register read/write strobes.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no frame; waits for an armed ss_n falling edge
// HEADER | shifting in 1 R/W bit + ADDR_WIDTH address bits
// DATA   | shifting DATA_WIDTH-bit words (burst), serialising reads on miso
module spi_register_port #(
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  ss_n,
    input  logic                  sclk,
    input  logic                  mosi,
    output logic                  miso,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wr_data,
    output logic                  reg_wr_en,
    output logic                  reg_rd_en,
    input  logic [DATA_WIDTH-1:0] reg_rd_data,
    output logic                  frame_active,
    output logic                  frame_error
);

    localparam int MAX_BITS = (ADDR_WIDTH + 1 > DATA_WIDTH) ? ADDR_WIDTH + 1 : DATA_WIDTH;
    localparam int CNT_W    = $clog2(MAX_BITS + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HEADER = 2'd1,
        ST_DATA   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   ss_prev_q, ss_prev_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   armed_q, armed_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [ADDR_WIDTH:0]    hdr_q, hdr_d;
    logic [DATA_WIDTH-1:0]  wr_shift_q, wr_shift_d;
    logic [DATA_WIDTH-1:0]  rd_shift_q, rd_shift_d;
    logic                   rw_q, rw_d;
    logic                   rd_cap_q, rd_cap_d;
    logic [ADDR_WIDTH-1:0]  reg_addr_q, reg_addr_d;
    logic [DATA_WIDTH-1:0]  reg_wr_data_q, reg_wr_data_d;
    logic                   reg_wr_en_q, reg_wr_en_d;
    logic                   reg_rd_en_q, reg_rd_en_d;
    logic                   miso_q, miso_d;
    logic                   frame_active_q, frame_active_d;
    logic                   frame_error_q, frame_error_d;

    logic                   ss_last, sclk_last, mosi_last;
    logic                   ss_rise, ss_fall, sclk_rise, sclk_fall;
    logic [ADDR_WIDTH:0]    hdr_next;
    logic [DATA_WIDTH-1:0]  wr_shift_next;

    assign ss_last       = ss_sync_q[SYNC_STAGES-1];
    assign sclk_last     = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_last     = mosi_sync_q[SYNC_STAGES-1];
    assign ss_rise       = ss_last & ~ss_prev_q;
    assign ss_fall       = ~ss_last & ss_prev_q;
    assign sclk_rise     = sclk_last & ~sclk_prev_q;
    assign sclk_fall     = ~sclk_last & sclk_prev_q;
    assign hdr_next      = {hdr_q[ADDR_WIDTH-1:0], mosi_last};
    assign wr_shift_next = {wr_shift_q[DATA_WIDTH-2:0], mosi_last};

    always_comb begin
        state_d        = state_q;
        ss_sync_d      = {ss_sync_q[SYNC_STAGES-2:0], ss_n};
        sclk_sync_d    = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        mosi_sync_d    = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        ss_prev_d      = ss_last;
        sclk_prev_d    = sclk_last;
        armed_d        = armed_q | ss_last;
        bit_cnt_d      = bit_cnt_q;
        hdr_d          = hdr_q;
        wr_shift_d     = wr_shift_q;
        rd_shift_d     = rd_shift_q;
        rw_d           = rw_q;
        rd_cap_d       = reg_rd_en_q;
        reg_addr_d     = reg_addr_q;
        reg_wr_data_d  = reg_wr_data_q;
        reg_wr_en_d    = 1'b0;
        reg_rd_en_d    = 1'b0;
        miso_d         = miso_q;
        frame_active_d = frame_active_q;
        frame_error_d  = 1'b0;

        // Address auto-increments after every strobe so bursts walk (and wrap) naturally.
        if (reg_wr_en_q || reg_rd_en_q) begin
            reg_addr_d = reg_addr_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                if (ss_fall && armed_q) begin
                    state_d        = ST_HEADER;
                    frame_active_d = 1'b1;
                    bit_cnt_d      = '0;
                    hdr_d          = '0;
                end
            end
            ST_HEADER, ST_DATA: begin
                if (ss_rise) begin
                    // ss_n wins over a coincident sclk edge; any partial word is dropped.
                    state_d        = ST_IDLE;
                    frame_active_d = 1'b0;
                    miso_d         = 1'b0;
                    frame_error_d  = (bit_cnt_q != '0);
                    bit_cnt_d      = '0;
                end else if (state_q == ST_HEADER) begin
                    if (sclk_rise) begin
                        hdr_d = hdr_next;
                        if (bit_cnt_q == CNT_W'(ADDR_WIDTH)) begin
                            reg_addr_d  = hdr_next[ADDR_WIDTH-1:0];
                            rw_d        = hdr_next[ADDR_WIDTH];
                            reg_rd_en_d = ~hdr_next[ADDR_WIDTH];
                            state_d     = ST_DATA;
                            bit_cnt_d   = '0;
                            wr_shift_d  = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end else begin
                    if (sclk_rise) begin
                        wr_shift_d = wr_shift_next;
                        if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                            bit_cnt_d = '0;
                            if (rw_q) begin
                                reg_wr_en_d   = 1'b1;
                                reg_wr_data_d = wr_shift_next;
                            end else begin
                                reg_rd_en_d = 1'b1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                    if (sclk_fall && !rw_q) begin
                        miso_d     = rd_shift_q[DATA_WIDTH-1];
                        rd_shift_d = rd_shift_q << 1;
                    end
                end
            end
            default: begin
                state_d        = ST_IDLE;
                frame_active_d = 1'b0;
                miso_d         = 1'b0;
            end
        endcase

        // A fresh read word replaces whatever is left in the shifter.
        if (rd_cap_q) begin
            rd_shift_d = reg_rd_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            ss_sync_q      <= '0;
            sclk_sync_q    <= '0;
            mosi_sync_q    <= '0;
            ss_prev_q      <= 1'b0;
            sclk_prev_q    <= 1'b0;
            armed_q        <= 1'b0;
            bit_cnt_q      <= '0;
            hdr_q          <= '0;
            wr_shift_q     <= '0;
            rd_shift_q     <= '0;
            rw_q           <= 1'b0;
            rd_cap_q       <= 1'b0;
            reg_addr_q     <= '0;
            reg_wr_data_q  <= '0;
            reg_wr_en_q    <= 1'b0;
            reg_rd_en_q    <= 1'b0;
            miso_q         <= 1'b0;
            frame_active_q <= 1'b0;
            frame_error_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            ss_sync_q      <= ss_sync_d;
            sclk_sync_q    <= sclk_sync_d;
            mosi_sync_q    <= mosi_sync_d;
            ss_prev_q      <= ss_prev_d;
            sclk_prev_q    <= sclk_prev_d;
            armed_q        <= armed_d;
            bit_cnt_q      <= bit_cnt_d;
            hdr_q          <= hdr_d;
            wr_shift_q     <= wr_shift_d;
            rd_shift_q     <= rd_shift_d;
            rw_q           <= rw_d;
            rd_cap_q       <= rd_cap_d;
            reg_addr_q     <= reg_addr_d;
            reg_wr_data_q  <= reg_wr_data_d;
            reg_wr_en_q    <= reg_wr_en_d;
            reg_rd_en_q    <= reg_rd_en_d;
            miso_q         <= miso_d;
            frame_active_q <= frame_active_d;
            frame_error_q  <= frame_error_d;
        end
    end

    assign miso         = miso_q;
    assign reg_addr     = reg_addr_q;
    assign reg_wr_data  = reg_wr_data_q;
    assign reg_wr_en    = reg_wr_en_q;
    assign reg_rd_en    = reg_rd_en_q;
    assign frame_active = frame_active_q;
    assign frame_error  = frame_error_q;

endmodule

// File: tb/tb_spi_register_port.sv
// Scoreboarded bench for spi_register_port: SPI frames in, register strobes and miso out.
module tb_spi_register_port;

    localparam int AW = 7;
    localparam int DW = 32;
    localparam int H  = 5;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          ss_n = 1'b1;
    logic          sclk = 1'b0;
    logic          mosi = 1'b0;
    logic          miso;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_wr_data;
    logic          reg_wr_en;
    logic          reg_rd_en;
    logic [DW-1:0] reg_rd_data = '0;
    logic          frame_active;
    logic          frame_error;

    int n_vec = 0;
    int n_err = 0;
    int err_seen = 0;
    int cyc = 0;
    int last_strobe = -100;

    logic [AW+DW-1:0] exp_wr_q[$];
    logic [AW-1:0]    exp_rd_q[$];

    spi_register_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
        .clock(clock), .reset_n(reset_n), .ss_n(ss_n), .sclk(sclk), .mosi(mosi),
        .miso(miso), .reg_addr(reg_addr), .reg_wr_data(reg_wr_data),
        .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data),
        .frame_active(frame_active), .frame_error(frame_error)
    );

    always #5 clock = ~clock;

    function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
        if (a == 7'h12) return 32'hA5A50F0F;
        return {8'hC3, 17'h0, a};
    endfunction

    // Register file model: read data presented the cycle after the request.
    initial begin
        forever begin
            @(negedge clock);
            if (reg_rd_en === 1'b1) reg_rd_data = rd_model(reg_addr);
        end
    end

    // Strobe monitor / scoreboard consumer.
    always @(negedge clock) begin
        cyc++;
        if (frame_error === 1'b1) err_seen++;
        if (reg_wr_en === 1'b1 || reg_rd_en === 1'b1) begin
            n_vec++;
            if (cyc - last_strobe < 3) begin
                n_err++;
                $display("FAIL strobe_spacing: gap %0d cycles, need >= 3", cyc - last_strobe);
            end
            last_strobe = cyc;
        end
        if (reg_wr_en === 1'b1) begin
            n_vec++;
            if (exp_wr_q.size() == 0) begin
                n_err++;
                $display("FAIL wr_unexpected: addr=%h data=%h, none expected", reg_addr, reg_wr_data);
            end else begin
                logic [AW+DW-1:0] e;
                e = exp_wr_q.pop_front();
                if ({reg_addr, reg_wr_data} !== e)
                begin
                    n_err++;
                    $display("FAIL wr_strobe: addr=%h data=%h, expected addr=%h data=%h",
                             reg_addr, reg_wr_data, e[AW+DW-1:DW], e[DW-1:0]);
                end
            end
        end
        if (reg_rd_en === 1'b1) begin
            n_vec++;
            if (exp_rd_q.size() == 0) begin
                n_err++;
                $display("FAIL rd_unexpected: addr=%h, none expected", reg_addr);
            end else begin
                logic [AW-1:0] ea;
                ea = exp_rd_q.pop_front();
                if (reg_addr !== ea) begin
                    n_err++;
                    $display("FAIL rd_strobe: addr=%h, expected %h", reg_addr, ea);
                end
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic spi_send(input logic [63:0] v, input int n, output logic [63:0] rx);
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = v[i];
            wait_clk(H);
            rx = {rx[62:0], miso};
            sclk = 1'b1;
            wait_clk(H);
            sclk = 1'b0;
        end
    endtask

    task automatic frame_start();
        ss_n = 1'b0;
        wait_clk(H);
    endtask

    task automatic frame_end();
        wait_clk(H);
        ss_n = 1'b1;
        wait_clk(3 * H);
    endtask

    task automatic check_drained(input string tag);
        n_vec++;
        if (exp_wr_q.size() != 0 || exp_rd_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: %0d writes %0d reads outstanding, expected 0",
                     tag, exp_wr_q.size(), exp_rd_q.size());
            exp_wr_q.delete();
            exp_rd_q.delete();
        end
    endtask

    task automatic check_errs(input string tag, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s_frame_error: %0d pulses, expected %0d", tag, got, want);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        n_vec++;
        if ({frame_active, miso} !== 2'b00) begin
            n_err++;
            $display("FAIL %s_idle: frame_active=%b miso=%b, expected 0 0", tag, frame_active, miso);
        end
    endtask

    task automatic write_frame(input logic [7:0] hdr, input logic [DW-1:0] d);
        logic [63:0] rx;
        frame_start();
        spi_send({56'h0, hdr}, 8, rx);
        spi_send({32'h0, d}, DW, rx);
        frame_end();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        ss_n = 1'b1;
        wait_clk(3);
        n_vec++;
        if ({miso, reg_addr, reg_wr_data, reg_wr_en, reg_rd_en, frame_active, frame_error} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: addr=%h data=%h wr=%b rd=%b act=%b err=%b miso=%b, expected all 0",
                     reg_addr, reg_wr_data, reg_wr_en, reg_rd_en, frame_active, frame_error, miso);
        end
        reset_n = 1'b1;
        wait_clk(6);
        check_idle_outputs("reset_release");
    endtask

    task automatic test_write();
        logic [63:0] rx;
        int e0;
        e0 = err_seen;
        exp_wr_q.push_back({7'h05, 32'hDEADBEEF});
        frame_start();
        spi_send(64'h85, 8, rx);
        n_vec++;
        if (frame_active !== 1'b1) begin
            n_err++;
            $display("FAIL write_active: frame_active=%b, expected 1", frame_active);
        end
        spi_send(64'hDEADBEEF, DW, rx);
        frame_end();
        check_drained("write");
        check_errs("write", err_seen - e0, 0);
        check_idle_outputs("write");
    endtask

    task automatic test_read();
        logic [63:0] rx;
        int e0;
        e0 = err_seen;
        exp_rd_q.push_back(7'h12);
        exp_rd_q.push_back(7'h13);
        frame_start();
        spi_send(64'h12, 8, rx);
        spi_send(64'h0, DW, rx);
        n_vec++;
        if (rx[31:0] !== 32'hA5A50F0F) begin
            n_err++;
            $display("FAIL read_miso: got %h, expected a5a50f0f", rx[31:0]);
        end
        frame_end();
        check_drained("read");
        check_errs("read", err_seen - e0, 0);
        check_idle_outputs("read");
    endtask

    task automatic test_burst_wrap();
        logic [63:0] rx;
        int e0;
        e0 = err_seen;
        exp_wr_q.push_back({7'h7F, 32'd1});
        exp_wr_q.push_back({7'h00, 32'd2});
        exp_wr_q.push_back({7'h01, 32'd3});
        frame_start();
        spi_send(64'hFF, 8, rx);
        for (int w = 1; w <= 3; w++) spi_send(64'(w), DW, rx);
        frame_end();
        check_drained("burst");
        check_errs("burst", err_seen - e0, 0);
    endtask

    task automatic test_abort();
        logic [63:0] rx;
        int e0;
        e0 = err_seen;
        frame_start();
        spi_send(64'h83, 8, rx);
        spi_send(64'h1FFFF, 17, rx);
        frame_end();
        check_errs("abort", err_seen - e0, 1);
        check_idle_outputs("abort");
        check_drained("abort");
        e0 = err_seen;
        exp_wr_q.push_back({7'h03, 32'h12345678});
        write_frame(8'h83, 32'h12345678);
        check_drained("after_abort");
        check_errs("after_abort", err_seen - e0, 0);
    endtask

    task automatic test_reset_midframe();
        logic [63:0] rx;
        int e0;
        frame_start();
        spi_send(64'h10, 5, rx);
        reset_n = 1'b0;
        wait_clk(3);
        reset_n = 1'b1;
        e0 = err_seen;
        spi_send(64'hA5A5A, 20, rx);
        check_idle_outputs("midreset");
        check_errs("midreset", err_seen - e0, 0);
        ss_n = 1'b1;
        wait_clk(3 * H);
        exp_wr_q.push_back({7'h01, 32'h00000001});
        write_frame(8'h81, 32'h00000001);
        check_drained("midreset");
        check_errs("midreset_write", err_seen - e0, 0);
    endtask

    task automatic test_idle_noise();
        int e0;
        int bad;
        e0 = err_seen;
        bad = 0;
        ss_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            mosi = 1'($urandom_range(0, 1));
            sclk = ~sclk;
            wait_clk(3);
            if (frame_active !== 1'b0 || miso !== 1'b0) bad++;
        end
        sclk = 1'b0;
        wait_clk(6);
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL noise_idle: %0d samples with activity, expected 0", bad);
        end
        check_errs("noise", err_seen - e0, 0);
        check_drained("noise");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_burst_wrap();
        test_abort();
        test_reset_midframe();
        test_idle_noise();
        wait_clk(10);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
